// File: rtl/trap_sequencer_pkg.sv
// Shared trap sequencer definitions: state encoding, cause codes, mtvec modes, CSR record.
// Optional vectored trap support is selected by the TRAP_VECTORED_EN macro.
package trap_sequencer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_SAVE     = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_WFI      = 3'd4
  } state_t;

  localparam logic [CODE_W-1:0] EXC_ILLEGAL    = 5'd2;
  localparam logic [CODE_W-1:0] EXC_BREAKPOINT = 5'd3;
  localparam logic [CODE_W-1:0] EXC_ECALL_U    = 5'd8;
  localparam logic [CODE_W-1:0] EXC_ECALL_S    = 5'd9;
  localparam logic [CODE_W-1:0] EXC_ECALL_M    = 5'd11;

  localparam logic [CODE_W-1:0] IRQ_MSI = 5'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI = 5'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI = 5'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Latched trap CSR write bundle
  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
  } trap_rec_t;

endpackage

// File: rtl/trap_sequencer_irq_priority_enc.sv
// Pending-interrupt priority encoder: MEI(11) > MSI(3) > MTI(7) > lowest remaining bit.
module irq_priority_enc
  import trap_sequencer_pkg::*;
(
  input  logic [XLEN-1:0]   pending,
  output logic [CODE_W-1:0] code_c,
  output logic              valid_c
);

  always_comb begin
    valid_c = |pending;
    code_c  = '0;
    if (pending[IRQ_MEI]) begin
      code_c = IRQ_MEI;
    end else if (pending[IRQ_MSI]) begin
      code_c = IRQ_MSI;
    end else if (pending[IRQ_MTI]) begin
      code_c = IRQ_MTI;
    end else begin
      // Scan downward so the lowest set bit is the last to win
      for (int i = XLEN - 1; i >= 0; i--) begin
        if (pending[i]) code_c = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: drains the pipe, writes trap CSRs, redirects the PC.
// Define TRAP_VECTORED_EN for vectored interrupt targets when mtvec mode is 01.
module trap_sequencer
  import trap_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid,
  input  logic [4:0]        exc_code,
  input  logic [XLEN-1:0]   exc_tval,
  input  logic [XLEN-1:0]   cur_pc,
  input  logic [XLEN-1:0]   irq_pending,
  input  logic              mie_global,
  input  logic              is_mret,
  input  logic              is_wfi,
  input  logic [XLEN-1:0]   mepc_in,
  input  logic [XLEN-1:0]   mtvec_in,
  input  logic              pipe_drained,
  output logic              stall,
  output logic              flush,
  output logic              busy,
  output logic              csr_we,
  output logic [XLEN-1:0]   csr_cause,
  output logic [XLEN-1:0]   csr_epc,
  output logic [XLEN-1:0]   csr_tval,
  output logic              trap_enter,
  output logic              trap_return,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   pc_target
);

  state_t      state, state_nxt;
  trap_rec_t   rec, rec_nxt;
  logic [CODE_W-1:0] irq_code;
  logic        irq_any;
  logic [XLEN-1:0] trap_base, trap_vec;

  logic            stall_nxt, flush_nxt, busy_nxt, csr_we_nxt;
  logic            trap_enter_nxt, trap_return_nxt, pc_redirect_nxt;
  logic [XLEN-1:0] csr_cause_nxt, csr_epc_nxt, csr_tval_nxt, pc_target_nxt;

  irq_priority_enc u_irq_priority_enc (
    .pending (irq_pending),
    .code_c  (irq_code),
    .valid_c (irq_any)
  );

  // Trap vector target from the latched cause
  assign trap_base = {mtvec_in[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign trap_vec = (mtvec_in[1:0] == MTVEC_VECTORED && rec.cause[XLEN-1])
                  ? trap_base + {25'b0, rec.cause[CODE_W-1:0], 2'b00}
                  : trap_base;
`else
  logic unused_mode;
  assign unused_mode = ^mtvec_in[1:0];
  assign trap_vec    = trap_base;
`endif

  // Next state, latched record and next registered outputs
  always_comb begin
    state_nxt       = state;
    rec_nxt         = rec;
    pc_target_nxt   = '0;
    trap_return_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (exc_valid) begin
          rec_nxt   = '{cause: {27'b0, exc_code}, epc: cur_pc, tval: exc_tval};
          state_nxt = ST_DRAIN;
        end else if (is_mret) begin
          pc_target_nxt   = mepc_in;
          trap_return_nxt = 1'b1;
          state_nxt       = ST_REDIRECT;
        end else if (mie_global && irq_any) begin
          rec_nxt   = '{cause: {1'b1, 26'b0, irq_code}, epc: cur_pc, tval: '0};
          state_nxt = ST_DRAIN;
        end else if (is_wfi) begin
          state_nxt = ST_WFI;
        end
      end
      ST_DRAIN:    if (pipe_drained) state_nxt = ST_SAVE;
      ST_SAVE: begin
        pc_target_nxt = trap_vec;
        state_nxt     = ST_REDIRECT;
      end
      ST_REDIRECT: state_nxt = ST_IDLE;
      ST_WFI: begin
        if (irq_any) begin
          if (mie_global) begin
            rec_nxt   = '{cause: {1'b1, 26'b0, irq_code}, epc: cur_pc + 32'd4, tval: '0};
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default:     state_nxt = ST_IDLE;
    endcase

    busy_nxt        = (state_nxt != ST_IDLE);
    stall_nxt       = busy_nxt;
    flush_nxt       = (state_nxt == ST_DRAIN);
    csr_we_nxt      = (state_nxt == ST_SAVE);
    trap_enter_nxt  = csr_we_nxt;
    pc_redirect_nxt = (state_nxt == ST_REDIRECT);
    csr_cause_nxt   = csr_we_nxt ? rec_nxt.cause : '0;
    csr_epc_nxt     = csr_we_nxt ? rec_nxt.epc   : '0;
    csr_tval_nxt    = csr_we_nxt ? rec_nxt.tval  : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rec         <= '0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      busy        <= 1'b0;
      csr_we      <= 1'b0;
      csr_cause   <= '0;
      csr_epc     <= '0;
      csr_tval    <= '0;
      trap_enter  <= 1'b0;
      trap_return <= 1'b0;
      pc_redirect <= 1'b0;
      pc_target   <= '0;
    end else begin
      state       <= state_nxt;
      rec         <= rec_nxt;
      stall       <= stall_nxt;
      flush       <= flush_nxt;
      busy        <= busy_nxt;
      csr_we      <= csr_we_nxt;
      csr_cause   <= csr_cause_nxt;
      csr_epc     <= csr_epc_nxt;
      csr_tval    <= csr_tval_nxt;
      trap_enter  <= trap_enter_nxt;
      trap_return <= trap_return_nxt;
      pc_redirect <= pc_redirect_nxt;
      pc_target   <= pc_target_nxt;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized traffic vs a model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst, exc_valid, mie_global, is_mret, is_wfi, pipe_drained;
  logic [4:0]  exc_code;
  logic [31:0] exc_tval, cur_pc, irq_pending, mepc_in, mtvec_in;
  logic        stall, flush, busy, csr_we, trap_enter, trap_return, pc_redirect;
  logic [31:0] csr_cause, csr_epc, csr_tval, pc_target;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we    = 0;
  int n_redir = 0;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
    .cur_pc(cur_pc), .irq_pending(irq_pending), .mie_global(mie_global), .is_mret(is_mret),
    .is_wfi(is_wfi), .mepc_in(mepc_in), .mtvec_in(mtvec_in), .pipe_drained(pipe_drained),
    .stall(stall), .flush(flush), .busy(busy), .csr_we(csr_we), .csr_cause(csr_cause),
    .csr_epc(csr_epc), .csr_tval(csr_tval), .trap_enter(trap_enter), .trap_return(trap_return),
    .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  // Behavioural model: a phase name plus the pending trap record
  typedef enum {P_IDLE, P_DRAIN, P_SAVE, P_REDIRECT, P_WFI} phase_t;
  phase_t      m_phase = P_IDLE;
  logic [31:0] m_cause = 0, m_epc = 0, m_tval = 0, m_tgt = 0;
  logic        m_ret = 0;

  function automatic int pick_irq(input logic [31:0] p);
    int order [3] = '{11, 3, 7};
    foreach (order[k]) if (p[order[k]]) return order[k];
    for (int i = 0; i < 32; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] vector_of(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
    if (mtvec[1:0] == 2'b01 && cause[31]) return base + 4 * (cause & 32'h1F);
`endif
    return base;
  endfunction

  task automatic take_trap(input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval);
    m_cause = cause; m_epc = epc; m_tval = tval; m_phase = P_DRAIN;
  endtask

  // Advance the model on the inputs the DUT samples at this edge
  task automatic model_step();
    if (rst) begin
      m_phase = P_IDLE; m_cause = 0; m_epc = 0; m_tval = 0; m_tgt = 0; m_ret = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (exc_valid) take_trap(32'(exc_code), cur_pc, exc_tval);
        else if (is_mret) begin m_phase = P_REDIRECT; m_tgt = mepc_in; m_ret = 1; end
        else if (mie_global && irq_pending != 0) take_trap(32'h8000_0000 | pick_irq(irq_pending), cur_pc, 0);
        else if (is_wfi) m_phase = P_WFI;
      end
      P_DRAIN: if (pipe_drained) m_phase = P_SAVE;
      P_SAVE: begin m_phase = P_REDIRECT; m_tgt = vector_of(mtvec_in, m_cause); m_ret = 0; end
      P_REDIRECT: m_phase = P_IDLE;
      P_WFI: if (irq_pending != 0) begin
        if (mie_global) take_trap(32'h8000_0000 | pick_irq(irq_pending), cur_pc + 4, 0);
        else m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic sv, rd;
    sv = (m_phase == P_SAVE);
    rd = (m_phase == P_REDIRECT);
    check("busy",        32'(busy),        32'(m_phase != P_IDLE));
    check("stall",       32'(stall),       32'(m_phase != P_IDLE));
    check("flush",       32'(flush),       32'(m_phase == P_DRAIN));
    check("csr_we",      32'(csr_we),      32'(sv));
    check("trap_enter",  32'(trap_enter),  32'(sv));
    check("csr_cause",   csr_cause,        sv ? m_cause : 0);
    check("csr_epc",     csr_epc,          sv ? m_epc : 0);
    check("csr_tval",    csr_tval,         sv ? m_tval : 0);
    check("pc_redirect", 32'(pc_redirect), 32'(rd));
    check("trap_return", 32'(trap_return), 32'(rd && m_ret));
    check("pc_target",   pc_target,        rd ? m_tgt : 0);
    if (csr_we === 1'b1) n_we++;
    if (pc_redirect === 1'b1) n_redir++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    exc_valid = 0; exc_code = 0; exc_tval = 0; cur_pc = 0; irq_pending = 0; mie_global = 0;
    is_mret = 0; is_wfi = 0; mepc_in = 0; mtvec_in = 32'h800; pipe_drained = 1;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    check("reset_busy", 32'(busy), 0);
    check("reset_target", pc_target, 0);
    step();
    check("post_reset_stall", 32'(stall), 0);

    // Illegal instruction: fixed latency and CSR values
    exc_valid = 1; exc_code = 5'd2; cur_pc = 32'h100; exc_tval = 32'hDEAD; mtvec_in = 32'h800;
    step(); exc_valid = 0;
    check("exc_flush_n1", 32'(flush), 1);
    step();
    check("exc_we_n2", 32'(csr_we), 1);
    check("exc_cause", csr_cause, 32'h2);
    check("exc_epc", csr_epc, 32'h100);
    check("exc_tval", csr_tval, 32'hDEAD);
    step();
    check("exc_redirect_n3", 32'(pc_redirect), 1);
    check("exc_target", pc_target, 32'h800);
    step();
    check("exc_idle_n4", 32'(busy), 0);

    // Interrupt priority and vectored target
    irq_pending = 32'h888; mie_global = 1; mtvec_in = 32'h801;
    step(); irq_pending = 0;
    step();
    check("irq_cause_mei", csr_cause, 32'h8000_000B);
    step();
`ifdef TRAP_VECTORED_EN
    check("irq_target_vec", pc_target, 32'h82C);
`else
    check("irq_target_base", pc_target, 32'h800);
`endif
    step();

    // Exception wins over simultaneous interrupt, interrupt follows
    mtvec_in = 32'h800; exc_valid = 1; exc_code = 5'd2; irq_pending = 32'h80; mie_global = 1;
    step(); exc_valid = 0;
    step();
    check("simul_exc_first", csr_cause, 32'h2);
    step(); step(); step();
    irq_pending = 0;
    check("simul_irq_flush", 32'(flush), 1);
    step();
    check("simul_irq_cause", csr_cause, 32'h8000_0007);
    step(); step();

    // WFI woken with interrupts globally disabled: back to idle, no trap
    n_we = 0; cur_pc = 32'h200; mie_global = 0; is_wfi = 1;
    step(); is_wfi = 0;
    for (int i = 0; i < 5; i++) begin
      check("wfi_stall", 32'(stall), 1);
      step();
    end
    irq_pending = 32'h8;
    step();
    check("wfi_release", 32'(stall), 0);
    check("wfi_no_we", 32'(n_we), 0);
    irq_pending = 0;
    step();

    // WFI woken with interrupts enabled: trap with epc after the wfi
    mie_global = 1; is_wfi = 1;
    step(); is_wfi = 0;
    repeat (5) step();
    irq_pending = 32'h8;
    step(); irq_pending = 0;
    step();
    check("wfi_trap_epc", csr_epc, 32'h204);
    check("wfi_trap_cause", csr_cause, 32'h8000_0003);
    step(); step();

    // mret goes straight to the redirect
    mepc_in = 32'h1234; is_mret = 1;
    step(); is_mret = 0;
    check("mret_target", pc_target, 32'h1234);
    check("mret_return", 32'(trap_return), 1);
    step();

    // Reset in the middle of a long drain
    n_we = 0; n_redir = 0; mie_global = 0;
    exc_valid = 1; exc_code = 5'd3; pipe_drained = 0;
    step(); exc_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    check("rst_drain_busy", 32'(busy), 0);
    check("rst_drain_flush", 32'(flush), 0);
    check("rst_drain_no_we", 32'(n_we), 0);
    check("rst_drain_no_redir", 32'(n_redir), 0);
    pipe_drained = 1;
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom % 150) == 0;
      exc_valid    = ($urandom % 8) == 0;
      exc_code     = 5'($urandom);
      exc_tval     = $urandom;
      cur_pc       = $urandom & 32'hFFFF_FFFC;
      irq_pending  = (($urandom % 6) == 0) ? (($urandom % 2) ? (32'h1 << ($urandom % 32)) : $urandom) : 0;
      mie_global   = $urandom % 2;
      is_mret      = ($urandom % 10) == 0;
      is_wfi       = ($urandom % 8) == 0;
      mepc_in      = $urandom;
      mtvec_in     = ($urandom & 32'hFFFF_FFFC) | 32'(($urandom % 2));
      pipe_drained = ($urandom % 3) != 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
